// File: rtl/sram_responder_if.sv
// Pin-level bundle between the SRAM controller and the SRAM responder model.
// The bidirectional data bus stays a plain port on the responder so the
// tri-state net is resolved at the top level.
interface sram_responder_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_WE_N;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              ready;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;
  logic              err_oor;

  modport master (
    output SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N,
    input  ready, rd_count, wr_count, err_oor
  );

  modport slave (
    input  SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N,
    output ready, rd_count, wr_count, err_oor
  );
endinterface

// File: rtl/sram_responder.sv
// Cycle-based model of a 16-bit asynchronous SRAM part, seen from its pins.
// Clears itself after reset, supports byte-lane writes, returns read data
// after a fixed pipeline latency on a tri-stated DQ, counts accesses and
// flags any access beyond the implemented depth.
module sram_responder #(
  parameter int ADDR_W       = 18,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [15:0]      SRAM_DQ,
  sram_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_ACTIVE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [15:0]       mem [DEPTH];
  logic [15:0]       out_reg;
  logic              have_data;
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [15:0]       pipe_data [READ_LATENCY];
  logic              ready_q;
  logic              err_q;
  logic [15:0]       rd_q;
  logic [15:0]       wr_q;

  logic              active;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       rd_word;
  logic              do_write;
  logic              do_read;
  logic              drive_rd;

  assign active   = (state == S_ACTIVE);
  assign in_range = ({1'b0, bus.SRAM_ADDR} < DEPTH_V);
  assign idx      = bus.SRAM_ADDR[IDX_W-1:0];
  assign rd_word  = in_range ? mem[idx] : 16'h0000;
  assign do_write = active && !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign do_read  = active && !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;

  // Single memory write port shared by the power-up clear and pin writes.
  logic              mem_we_hi;
  logic              mem_we_lo;
  logic [IDX_W-1:0]  mem_addr;
  logic [15:0]       mem_wdata;

  // Select the memory write source: clear sweep or byte-lane pin write.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    mem_we_hi = 1'b0;
    mem_we_lo = 1'b0;
    mem_addr  = '0;
    mem_wdata = 16'h0000;
    if (rst && state == S_CLEAR) begin
      mem_we_hi = 1'b1;
      mem_we_lo = 1'b1;
      mem_addr  = ptr;
    end else if (rst && do_write && in_range) begin
      mem_we_hi = !bus.SRAM_UB_N;
      mem_we_lo = !bus.SRAM_LB_N;
      mem_addr  = idx;
      mem_wdata = SRAM_DQ;
    end
  end

  // Storage array, written one byte lane at a time.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; the CLEAR sweep zeroes it instead,
    // which keeps it mappable onto block RAM.
    if (mem_we_hi) mem[mem_addr][15:8] <= mem_wdata[15:8];
    if (mem_we_lo) mem[mem_addr][7:0]  <= mem_wdata[7:0];
  end

  // Control FSM, read pipeline, output register, counters and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_CLEAR;
      ptr       <= '0;
      ready_q   <= 1'b0;
      rd_q      <= 16'h0000;
      wr_q      <= 16'h0000;
      err_q     <= 1'b0;
      pipe_vld  <= '0;
      have_data <= 1'b0;
      out_reg   <= 16'h0000;
    end else begin
      case (state)
        S_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == IDX_W'(DEPTH - 1)) begin
            state   <= S_ACTIVE;
            ready_q <= 1'b1;
          end
        end
        S_ACTIVE: begin
          for (int k = READ_LATENCY - 1; k > 0; k--) begin
            pipe_vld[k]  <= pipe_vld[k-1];
            pipe_data[k] <= pipe_data[k-1];
          end
          pipe_vld[0]  <= do_read;
          pipe_data[0] <= rd_word;
          if (pipe_vld[READ_LATENCY-1]) begin
            out_reg   <= pipe_data[READ_LATENCY-1];
            have_data <= 1'b1;
          end
          // NOTE: a deselect or write must win over the shift above; the later
          // non-blocking assignment in the same block takes precedence.
          if (bus.SRAM_CE_N || !bus.SRAM_WE_N) begin
            pipe_vld  <= '0;
            have_data <= 1'b0;
          end
          if (do_write && wr_q != 16'hFFFF) wr_q <= wr_q + 16'd1;
          if (do_read && rd_q != 16'hFFFF)  rd_q <= rd_q + 16'd1;
          if ((do_write || do_read) && !in_range) err_q <= 1'b1;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // DQ is driven per byte lane only while a read is presented on the pins.
  assign drive_rd = active && have_data && !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign SRAM_DQ[15:8] = (drive_rd && !bus.SRAM_UB_N) ? out_reg[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_rd && !bus.SRAM_LB_N) ? out_reg[7:0]  : 8'hzz;

  assign bus.ready    = ready_q;
  assign bus.rd_count = rd_q;
  assign bus.wr_count = wr_q;
  assign bus.err_oor  = err_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, cycle-based model of the external 16-bit SRAM device, i.e. the chip end of the SRAM pin interface driven by the data-memory SRAM controller.
- Instantiated in simulation/FPGA test tops in place of the physical part; the controller's SRAM_* pins connect to it directly.
- Provides power-up clearing, byte-lane writes, a read latency pipeline with tri-state DQ, access counters and an out-of-range error flag for verification of the controller and cache.

Parameters:
- ADDR_W, 18, width of SRAM_ADDR.
- DEPTH, 1024, number of implemented 16-bit words (addresses 0..DEPTH-1); must be ≤ 2^ADDR_W.
- READ_LATENCY, 2, clock edges from read-sampling edge to DQ driven; legal range 1..4.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- SRAM_DQ  inout  16  data bus; driven only during reads, else Z.
- SRAM_ADDR  in  ADDR_W  word address.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_UB_N  in  1  upper byte [15:8] enable, active-low.
- SRAM_LB_N  in  1  lower byte [7:0] enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- ready  out  1  high once power-up clear is done.
- rd_count  out  16  saturating count of launched reads.
- wr_count  out  16  saturating count of accepted writes.
- err_oor  out  1  sticky, access to address ≥ DEPTH.

Behaviour:
- Reset (rst=0 at edge): state←CLEAR, clear pointer←0, ready=0, rd_count=0, wr_count=0, err_oor=0, read pipeline valid bits←0, have_data←0, DQ=Z. Memory contents are not reset directly; they are cleared by CLEAR.
- FSM CLEAR: each edge writes 16'h0000 to mem[ptr], ptr++. After writing DEPTH-1, go to ACTIVE and set ready=1 on the next edge. CLEAR lasts exactly DEPTH cycles. All pin activity is ignored during CLEAR: no writes, no reads, no counts, no err_oor.
- Reset asserted mid-CLEAR or mid-ACTIVE restarts CLEAR from ptr 0. Any in-flight read is discarded.
- Write (ACTIVE, edge samples CE_N=0, WE_N=0):
  - mem[ADDR][15:8]←DQ[15:8] if UB_N=0; mem[ADDR][7:0]←DQ[7:0] if LB_N=0.
  - wr_count++ (saturating at 16'hFFFF) even if both lanes are disabled.
  - OE_N is ignored during writes.
  - have_data←0; the pipeline is flushed.
- Read launch (ACTIVE, edge samples CE_N=0, WE_N=1, OE_N=0):
  - Array word enters pipeline stage 1 with a valid bit; rd_count++ (saturating).
  - The pipeline advances every edge. On the edge where a valid word reaches stage READ_LATENCY, out_reg←word and have_data←1.
  - A new read may launch every cycle, so back-to-back reads give one word per cycle after the initial latency.
- DQ drive (combinational on current pins):
  - Upper byte = out_reg[15:8] when ACTIVE & have_data & CE_N=0 & WE_N=1 & OE_N=0 & UB_N=0, else Z.
  - Lower byte uses the same condition with LB_N and out_reg[7:0].
  - WE_N falling therefore releases DQ in the same cycle, so there is no bus contention with the controller.
- Deselect: an edge sampling CE_N=1 clears have_data and the pipeline valid bits. OE_N=1 alone only tri-states DQ; it keeps have_data.
- Read-after-write: a write at edge N followed by a read launched at edge N+1 returns the new data. There is no same-edge conflict, because WE_N selects exactly one operation.
- Out of range: when ADDR ≥ DEPTH, writes are dropped (counted), reads return 16'h0000 (counted), and err_oor←1 sticky until reset.
- Counters saturate and never wrap.

Test Plan:
1. Hold rst=0 for 3 cycles, release -> ready=0 for exactly DEPTH (1024) cycles then 1; DQ=Z throughout; a write attempted during CLEAR leaves wr_count=0.
2. After ready: write 16'hA5C3 to addr 5 (UB_N=LB_N=0), then read addr 5 with CE_N=OE_N=0, WE_N=1 -> DQ=16'hA5C3 exactly READ_LATENCY=2 edges after the launch edge, Z before; wr_count=1, rd_count=1.
3. Byte lanes: write 16'h1122 to addr 7 with UB_N=1, LB_N=0, then read with UB_N=0, LB_N=1 -> DQ=16'h00ZZ (upper byte zero from CLEAR, lower byte Z).
4. Back-to-back reads of addrs 0,1,2,3 holding OE_N=0 (after writing 0x10..0x13) -> DQ shows 0x10,0x11,0x12,0x13 on consecutive cycles starting at latency 2; rd_count=4.
5. Read addr 1024 (≥DEPTH) -> DQ=16'h0000 and err_oor=1, which persists after in-range accesses; write to 1024 leaves mem unchanged and wr_count increments.
6. Assert rst mid-read pipeline and mid-CLEAR (ptr≈500) -> DQ=Z immediately after the edge, counters=0, CLEAR restarts and ready rises only after a full DEPTH cycles.
